// File: rtl/seq_shift_pkg.sv
// Shared types and default sizing for the sequential shift unit.
package seq_shift_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_SHAMT_W = 2;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Operand/result valid-ready bus of the sequential shift unit.
interface seq_shift_unit_if #(
  parameter int unsigned WIDTH   = seq_shift_pkg::DEF_WIDTH,
  parameter int unsigned SHAMT_W = seq_shift_pkg::DEF_SHAMT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_ovf;

  modport master (
    output in_valid, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/seq_shift_unit_datapath.sv
// Shift register, remaining-shift down-counter and overflow accumulator.
module shift_datapath #(
  parameter int unsigned WIDTH   = seq_shift_pkg::DEF_WIDTH,
  parameter int unsigned SHAMT_W = seq_shift_pkg::DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   load_data,
  input  logic [SHAMT_W-1:0] load_shamt,
  output logic [WIDTH-1:0]   data,
  output logic               ovf,
  output logic               last_c
);

  logic [SHAMT_W-1:0] cnt;

  // Load wins over shift; neither leaves the result frozen for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      ovf  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      ovf  <= 1'b0;
      cnt  <= load_shamt;
    end else if (shift) begin
      ovf  <= ovf | data[WIDTH-1];
      data <= {data[WIDTH-2:0], 1'b0};
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

  assign last_c = (cnt == SHAMT_W'(1));

endmodule

// File: rtl/seq_shift_unit.sv
// Handshaked left shifter: one bit per clock, FSM and transaction counter.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_shift_unit_if.slave  bus,
  output logic [CNT_W-1:0] txn_count
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             shift_en;
  logic             last_c;
  logic             zero_shamt;
  logic [WIDTH-1:0] dp_data;
  logic             dp_ovf;

  assign accept     = bus.in_valid && bus.in_ready;
  assign zero_shamt = (bus.in_shamt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = zero_shamt ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (accept)             state_nxt = zero_shamt ? DONE : SHIFT;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A result drain and a new accept may share one edge.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    shift_en      = 1'b0;
    case (state)
      IDLE:    bus.in_ready = 1'b1;
      SHIFT:   shift_en     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      txn_count <= '0;
    else if (accept) txn_count <= txn_count + CNT_W'(1);
  end

  shift_datapath #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .shift      (shift_en),
    .load_data  (bus.in_data),
    .load_shamt (bus.in_shamt),
    .data       (dp_data),
    .ovf        (dp_ovf),
    .last_c     (last_c)
  );

  assign bus.out_data = dp_data;
  assign bus.out_ovf  = dp_ovf;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit against an arithmetic shift model.
module tb_seq_shift_unit;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] txn_count;

  int checks;
  int failures;
  int exp_txn;

  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];

  seq_shift_unit_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of d << s as integer arithmetic: {ovf, truncated data}.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [SW-1:0] s);
    int full;
    full = int'(d) << int'(s);
    return {((full >> W) != 0), W'(full)};
  endfunction

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_txn = 0;
  endtask

  // Drives one operand with out_ready high; reports latency and result seen.
  task automatic run_op(input logic [W-1:0] d, input logic [SW-1:0] s,
                        output int lat, output logic [W-1:0] od, output logic oovf);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_shamt = s; bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    exp_txn++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_shamt = SW'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    od   = bus.out_data;
    oovf = bus.out_ovf;
  endtask

  // Streams n operands; mode 0 sweep shamt=1, 1 random with backpressure, 2 random shamt=0.
  task automatic run_stream(input int n, input int mode);
    int idx, cyc;
    bit have;
    logic [W-1:0]  cd;
    logic [SW-1:0] cs;
    exp_q.delete(); got_q.delete();
    idx = 0; cyc = 0; have = 0; cd = '0; cs = '0;
    while (got_q.size() < n && cyc < 20 * n + 100) begin
      @(negedge clk);
      if (!have && idx < n) begin
        have = 1;
        cd = (mode == 0) ? W'(idx) : W'($urandom);
        cs = (mode == 0) ? SW'(1) : (mode == 2) ? SW'(0) : SW'($urandom);
      end
      bus.in_valid  = have;
      bus.in_data   = cd;
      bus.in_shamt  = cs;
      bus.out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_ovf, bus.out_data});
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(cd, cs));
        idx++; have = 0; exp_txn++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
    checks++; if (txn_count !== '0) begin failures++; $display("FAIL reset_txn_count got=%0d exp=0", txn_count); end
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] od; logic ov;
    run_op(4'b0011, 2'd1, lat, od, ov);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (od !== 4'b0110) begin failures++; $display("FAIL basic_data got=%b exp=0110", od); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ov); end
  endtask

  task automatic test_overflow();
    int lat; logic [W-1:0] od; logic ov;
    run_op(4'b1011, 2'd2, lat, od, ov);
    checks++; if (lat != 3) begin failures++; $display("FAIL ovf1_latency got=%0d exp=3", lat); end
    checks++; if (od !== 4'b1100) begin failures++; $display("FAIL ovf1_data got=%b exp=1100", od); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf1_ovf got=%b exp=1", ov); end
    run_op(4'b1111, 2'd3, lat, od, ov);
    checks++; if (lat != 4) begin failures++; $display("FAIL ovf2_latency got=%0d exp=4", lat); end
    checks++; if (od !== 4'b1000) begin failures++; $display("FAIL ovf2_data got=%b exp=1000", od); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf2_ovf got=%b exp=1", ov); end
  endtask

  task automatic test_zero_shift();
    int lat; logic [W-1:0] od; logic ov;
    run_op(4'b0101, 2'd0, lat, od, ov);
    checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (od !== 4'b0101) begin failures++; $display("FAIL zero_data got=%b exp=0101", od); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", ov); end
  endtask

  task automatic test_backpressure();
    int n; logic [W:0] e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 4'b1001; bus.in_shamt = 2'd1; bus.out_ready = 1'b0;
    e = model(4'b1001, 2'd1);
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); exp_txn++;
    @(negedge clk);
    bus.in_data = 4'b0111; bus.in_shamt = 2'd0;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e[W-1:0] || bus.out_ovf !== e[W] || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%b o=%b r=%b exp v=1 d=%b o=%b r=0", i,
                 bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready, e[W-1:0], e[W]);
      end
      @(negedge clk);
    end
    checks++; if (int'(txn_count) != exp_txn) begin failures++; $display("FAIL bp_ignored_txn got=%0d exp=%0d", txn_count, exp_txn); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); exp_txn++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0111) begin
      failures++; $display("FAIL bp_b2b_result got v=%b d=%b exp v=1 d=0111", bus.out_valid, bus.out_data);
    end
    checks++; if (int'(txn_count) != exp_txn) begin failures++; $display("FAIL bp_b2b_txn got=%0d exp=%0d", txn_count, exp_txn); end
  endtask

  task automatic test_sweep();
    apply_reset();
    run_stream(16, 0);
    checks++; if (got_q.size() != 16) begin failures++; $display("FAIL sweep_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== {1'b0, W'(i << 1)} && !(i >= 8 && got_q[i] === {1'b1, W'(i << 1)})) begin
        failures++; $display("FAIL sweep_item i=%0d got=%b exp_data=%b", i, got_q[i], W'(i << 1));
      end
    end
    @(negedge clk);
    checks++; if (txn_count !== 8'd16) begin failures++; $display("FAIL sweep_txn got=%0d exp=16", txn_count); end
  endtask

  task automatic test_random();
    run_stream(60, 1);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_item i=%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (int'(txn_count) != (exp_txn % 256)) begin failures++; $display("FAIL rand_txn got=%0d exp=%0d", txn_count, exp_txn % 256); end
  endtask

  task automatic test_wrap();
    apply_reset();
    run_stream(260, 2);
    checks++; if (got_q.size() != 260) begin failures++; $display("FAIL wrap_count got=%0d exp=260", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_item i=%0d got=%b exp=%b", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (txn_count !== 8'd4) begin failures++; $display("FAIL wrap_txn got=%0d exp=4", txn_count); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 4'b0001; bus.in_shamt = 2'd3; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (txn_count !== '0) begin failures++; $display("FAIL rstmid_txn got=%0d exp=0", txn_count); end
    @(negedge clk);
    rst_n = 1'b1; exp_txn = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (bus.out_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_ghost_result got=%b exp=0", seen); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_txn = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero_shift();
    test_backpressure();
    test_sweep();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Sequential, handshaked left-shift unit: shifts a WIDTH-bit operand left by a programmable amount, one bit per clock, and returns the result.
- Asynchronous shift-left circuits are replaced by this block wherever timing or backpressure matters.
- Sits between a valid/ready operand producer and a valid/ready result consumer (e.g. a stimulus sequencer and a checker).

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SHAMT_W, 2, width of the shift-amount field; max shift = 2^SHAMT_W-1.
- CNT_W, 8, width of the accepted-transaction counter.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  in_data << in_shamt, truncated to WIDTH.
- out_ovf  output  1  1 if any 1-bit was shifted out of the MSB.
- txn_count  output  CNT_W  number of operands accepted since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_ovf=0; txn_count=0. Reset mid-operation discards the operand in flight; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- Accept: occurs on any edge with in_valid && in_ready. Latches in_data into the shift register, clears ovf, loads cnt=in_shamt and increments txn_count.
  - shamt==0: next state DONE.
  - shamt>0: next state SHIFT.
- SHIFT, each cycle:
  - ovf |= reg[WIDTH-1];
  - reg <= {reg[WIDTH-2:0],1'b0};
  - cnt <= cnt-1;
  - when cnt==1 this is the last shift, and the next state is DONE.
- Latency: an operand accepted at edge k gives out_valid=1 from edge k+shamt+1 onward. For shamt 0, that is 1 cycle.
- DONE: out_valid=1; out_data=reg; out_ovf=ovf. Both are held stable while out_ready=0 (no change under backpressure).
- in_ready = (state==IDLE) || (state==DONE && out_ready). A result drain and a new accept on the same edge are legal and give zero-bubble back-to-back operation.
- Result drained without a new accept: next state IDLE, out_valid=0. out_data keeps its last value (don't-care when out_valid=0).
- in_valid with in_ready=0 is ignored. The producer must hold its operand.
- in_data and in_shamt are sampled only on the accept edge; later changes have no effect.
- txn_count wraps 2^CNT_W-1 -> 0 silently.
- Width rule: bits shifted beyond WIDTH-1 are discarded. out_ovf is the OR of all discarded bits.

Decomposition:
- Shared package seq_shift_pkg holds the state enum (IDLE/SHIFT/DONE) and default WIDTH/SHAMT_W/CNT_W constants.
- One sub-module is natural: shift_datapath (register, down-counter, ovf accumulator, load/shift enables). The FSM and handshake stay in the top level.

Test Plan:
- Basic shift: in_data=4'b0011, shamt=1, out_ready=1 -> out_valid exactly 2 cycles after accept; out_data=4'b0110, out_ovf=0.
- Overflow: in_data=4'b1011, shamt=2 -> out_data=4'b1100, out_ovf=1, out_valid 3 cycles after accept. In_data=4'b1111, shamt=3 -> 4'b1000, ovf=1.
- Zero shift: in_data=4'b0101, shamt=0 -> out_data=4'b0101, ovf=0, out_valid the cycle after accept.
- Backpressure: shamt=1, hold out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and out_ovf stable and in_ready=0 throughout. Raising out_ready with in_valid high -> result drained and new operand accepted on the same edge.
- Sweep: in_data 0..15 back-to-back, shamt=1, out_ready=1 -> each out_data == (in_data<<1)&4'hF, no lost or duplicated results, txn_count=16.
- Reset mid-operation: accept 4'b0001 with shamt=3, assert rst_n low during SHIFT -> immediately in_ready=1, out_valid=0, txn_count=0. No result appears after release.
